sign_narrow: RTL

//  Narrows a 64-bit signed datapath value to OUT_WIDTH bits, the inverse of immediate sign extension.

---
 rtl/sign_narrow_pkg.sv | 12 +
 rtl/skid_buffer.sv | 49 ++++
 rtl/sign_narrow.sv | 54 +++++
 3 files changed

// File: rtl/sign_narrow_pkg.sv
// sign_narrow_pkg: shared narrow-store widths, result type and skid buffer state encoding
package sign_narrow_pkg;
   localparam int DATA_W   = 64;
   localparam int NARROW_B = 8;
   localparam int NARROW_H = 16;
   localparam int NARROW_W = 32;
   typedef struct packed {
      logic [DATA_W-2:0] data;
      logic              ovf;
   } narrow_res_t;
   typedef enum logic [1:0] {EMPTY, ONE, TWO} skid_state_t;
endpackage

// File: rtl/skid_buffer.sv
// skid_buffer: generic 2-entry valid/ready stage, in_ready decoded from registered state only
module skid_buffer
   import sign_narrow_pkg::*;
#(
   parameter int WIDTH = 8
) (
   input  logic             clk,
   input  logic             reset_n,
   input  logic             in_valid,
   output logic             in_ready,
   input  logic [WIDTH-1:0] in_data,
   output logic             out_valid,
   input  logic             out_ready,
   output logic [WIDTH-1:0] out_data
);
   skid_state_t      state;
   logic [WIDTH-1:0] skid;
   logic             acc, cons;
   assign in_ready  = state != TWO;
   assign out_valid = state != EMPTY;
   assign acc       = in_valid & in_ready;
   assign cons      = out_valid & out_ready;
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         state    <= EMPTY;
         out_data <= '0;
         skid     <= '0;
      end else begin
         case (state)
            EMPTY: if (acc) begin
               out_data <= in_data;
               state    <= ONE;
            end
            ONE: begin
               if (acc & cons) out_data <= in_data;
               else if (acc) begin
                  skid  <= in_data;
                  state <= TWO;
               end else if (cons) state <= EMPTY;
            end
            TWO: if (cons) begin
               out_data <= skid;
               state    <= ONE;
            end
            default: state <= EMPTY;
         endcase
      end
   end
endmodule

// File: rtl/sign_narrow.sv
// sign_narrow: narrows a signed 64-bit value to OUT_WIDTH bits with wrap/saturate and overflow stats
module sign_narrow
   import sign_narrow_pkg::*;
#(
   parameter int OUT_WIDTH   = NARROW_W,
   parameter int COUNT_WIDTH = 16
) (
   input  logic                   clk,
   input  logic                   reset_n,
   input  logic                   in_valid,
   output logic                   in_ready,
   input  logic [DATA_W-1:0]      in_data,
   input  logic                   in_sat,
   output logic                   out_valid,
   input  logic                   out_ready,
   output logic [OUT_WIDTH-1:0]   out_data,
   output logic                   out_ovf,
   output logic                   ovf_sticky,
   output logic [COUNT_WIDTH-1:0] ovf_count,
   input  logic                   stat_clr
);
   logic [DATA_W-OUT_WIDTH:0] top_bits;
   logic [OUT_WIDTH-1:0]      narrow;
   logic                      ovf, acc_ovf;
   // value fits only when every bit from the new sign position upward is a copy of the sign
   assign top_bits = in_data[DATA_W-1:OUT_WIDTH-1];
   assign ovf      = ~(&top_bits | ~|top_bits);
   assign narrow   = in_sat & ovf ? {in_data[DATA_W-1], {(OUT_WIDTH-1){~in_data[DATA_W-1]}}}
                                  : in_data[OUT_WIDTH-1:0];
   assign acc_ovf  = in_valid & in_ready & ovf;
   skid_buffer #(.WIDTH(OUT_WIDTH + 1)) u_skid (
      .clk       (clk),
      .reset_n   (reset_n),
      .in_valid  (in_valid),
      .in_ready  (in_ready),
      .in_data   ({ovf, narrow}),
      .out_valid (out_valid),
      .out_ready (out_ready),
      .out_data  ({out_ovf, out_data})
   );
   // a clear coinciding with a new event keeps that event
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         ovf_sticky <= 1'b0;
         ovf_count  <= '0;
      end else if (stat_clr) begin
         ovf_sticky <= acc_ovf;
         ovf_count  <= acc_ovf ? COUNT_WIDTH'(1) : '0;
      end else if (acc_ovf) begin
         ovf_sticky <= 1'b1;
         ovf_count  <= &ovf_count ? ovf_count : ovf_count + 1'b1;
      end
   end
endmodule
